spi_master_arbiter: RTL and testbench
=====================================

SPI_MASTER_ARBITER -- requirements
Module: spi_master_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2: number of requester ports (2..8).
REQ-002 SHALL have parameter N_BITS, default 32: maximum SPI packet width.
REQ-003 SHALL have parameter CS_BITS, default 2: chip-select address width.
REQ-004 SHALL have parameter TIMEOUT, default 1024: maximum cycles to wait for the SPI response.
REQ-005 SHALL derive localparam SIZE_W = $clog2(N_BITS)+1 and GID_W = $clog2(NUM_REQ).
REQ-006 SHALL have port clk, input, 1: the only clock, rising edge.
REQ-007 SHALL have port reset, input, 1: reset, asynchronous and active-high.
REQ-008 SHALL have ports req_val / req_rdy, input / output, NUM_REQ each: per-requester request handshake.
REQ-009 SHALL have ports req_msg, req_size and req_cs, inputs, NUM_REQ*N_BITS, NUM_REQ*SIZE_W and NUM_REQ*CS_BITS: packed per-requester data, bit count and chip-select address.
REQ-010 SHALL have ports resp_val / resp_rdy, output / input, NUM_REQ each: per-requester response handshake.
REQ-011 SHALL have ports resp_msg, output, N_BITS, and resp_err, output, 1: shared response payload and timeout flag.
REQ-012 SHALL have ports spi_packet_size_val, output, 1, and spi_packet_size, output, SIZE_W: master packet-size register enable and value.
REQ-013 SHALL have ports spi_cs_addr_val, output, 1, and spi_cs_addr, output, CS_BITS: master chip-select register enable and value.
REQ-014 SHALL have ports spi_recv_val, output, 1; spi_recv_rdy, input, 1; spi_recv_msg, output, N_BITS: request to master.
REQ-015 SHALL have ports spi_send_val, input, 1; spi_send_rdy, output, 1; spi_send_msg, input, N_BITS: response from master.
REQ-016 SHALL have ports busy, output, 1, and grant_id, output, GID_W: a transaction is in progress, and the index of the owning requester.

Function
REQ-017 SHALL implement the states IDLE, CONFIG, ISSUE, WAIT_RESP and RESP.
REQ-018 IDLE: SHALL pick the winner among req_val using round-robin, starting at priority pointer ptr and searching upward with wrap.
REQ-019 IDLE: SHALL assert req_rdy only for the winner, in the same cycle, combinationally; all other req_rdy stay 0.
REQ-020 On an IDLE fire, SHALL latch the winner's msg, cs and size, clamping size > N_BITS to N_BITS.
REQ-021 On an IDLE fire, SHALL set grant_id to the winner and go to CONFIG; if the latched size is 0, it SHALL instead go directly to RESP with resp_msg=0 and resp_err=0, with no SPI activity.
REQ-022 CONFIG: SHALL assert spi_packet_size_val and spi_cs_addr_val for exactly one cycle with the latched values, then go to ISSUE.
REQ-023 ISSUE: SHALL hold spi_recv_val=1 and spi_recv_msg = the latched msg until spi_recv_rdy=1, then go to WAIT_RESP.
REQ-024 WAIT_RESP: SHALL assert spi_send_rdy and increment a timeout counter that starts at 0.
REQ-025 WAIT_RESP: on spi_send_val, SHALL latch spi_send_msg into resp_msg, set resp_err=0 and go to RESP.
REQ-026 WAIT_RESP: if the counter reaches TIMEOUT-1 with no spi_send_val, SHALL set resp_msg=0, resp_err=1 and go to RESP.
REQ-027 WAIT_RESP: if spi_send_val arrives in the same cycle as the timeout expiry, SHALL treat it as success.
REQ-028 RESP: SHALL assert resp_val[grant_id] only and hold resp_msg/resp_err stable until resp_rdy[grant_id]=1.
REQ-029 On the RESP fire, SHALL set ptr = (grant_id+1) mod NUM_REQ and return to IDLE, so a new request can be accepted the cycle after.
REQ-030 IDLE: SHALL assert spi_send_rdy=1 and silently discard any spi_send_val (stale response after a timeout).
REQ-031 spi_send_rdy SHALL be 0 in CONFIG, ISSUE and RESP.
REQ-032 busy SHALL be 1 in every state except IDLE.
REQ-033 All data/address outputs SHALL be driven from registers; only the handshake signals are combinational from state and inputs.
REQ-034 A requester SHALL never receive req_rdy while another transaction is outstanding; there is at most one transaction in flight.

Reset
REQ-035 reset=1 SHALL asynchronously force state=IDLE, ptr=0, grant_id=0, timeout counter=0, resp_msg=0, resp_err=0 and all latched fields to 0.
REQ-036 While reset=1, all req_rdy, resp_val, spi_*_val and spi_send_rdy outputs SHALL be 0.
REQ-037 A reset during any state SHALL abort the transaction with no response issued; the first request after reset SHALL be arbitrated starting at requester 0.

Verification
REQ-038 Req0 msg=0xA5A5A5A5, size=32, cs=1 -> one-cycle cfg pulse; spi_recv_msg=0xA5A5A5A5; master returns 0x12345678 -> resp_val[0] with msg=0x12345678, err=0.
REQ-039 Req0 and req1 held valid continuously -> grants in the order 0,1,0,1; grant_id matches each response.
REQ-040 Req1 size=0 -> resp_val[1] within 2 cycles, msg=0, spi_recv_val never asserted.
REQ-041 Req0 size=40 -> spi_packet_size=32.
REQ-042 TIMEOUT=16, master never sends -> resp_err=1 and msg=0 after exactly 16 WAIT_RESP cycles; a late spi_send_val in IDLE is discarded and no resp_val results.
REQ-043 Assert reset in WAIT_RESP -> all handshake outputs 0 immediately, busy=0; a subsequent req1 is granted normally.

Source files
------------

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one SPI master among NUM_REQ requesters, one transaction in flight.
// Grant is same-cycle in IDLE; spi_recv_rdy and resp_rdy[grant_id] stall the FSM, TIMEOUT bounds the wait for the master.
module spi_master_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int N_BITS  = 32,
    parameter int CS_BITS = 2,
    parameter int TIMEOUT = 1024,
    localparam int SIZE_W = $clog2(N_BITS) + 1,
    localparam int GID_W  = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_val,
    output logic [NUM_REQ-1:0]         req_rdy,
    input  logic [NUM_REQ*N_BITS-1:0]  req_msg,
    input  logic [NUM_REQ*SIZE_W-1:0]  req_size,
    input  logic [NUM_REQ*CS_BITS-1:0] req_cs,
    output logic [NUM_REQ-1:0]         resp_val,
    input  logic [NUM_REQ-1:0]         resp_rdy,
    output logic [N_BITS-1:0]          resp_msg,
    output logic                       resp_err,
    output logic                       spi_packet_size_val,
    output logic [SIZE_W-1:0]          spi_packet_size,
    output logic                       spi_cs_addr_val,
    output logic [CS_BITS-1:0]         spi_cs_addr,
    output logic                       spi_recv_val,
    input  logic                       spi_recv_rdy,
    output logic [N_BITS-1:0]          spi_recv_msg,
    input  logic                       spi_send_val,
    output logic                       spi_send_rdy,
    input  logic [N_BITS-1:0]          spi_send_msg,
    output logic                       busy,
    output logic [GID_W-1:0]           grant_id
);
    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {IDLE, CONFIG, ISSUE, WAIT_RESP, RESP} state_t;

    typedef struct packed {
        logic [N_BITS-1:0]  msg;
        logic [CS_BITS-1:0] cs;
        logic [SIZE_W-1:0]  size;
    } hdr_t;

    state_t               state, state_nxt;
    hdr_t                 hdr, win_hdr;
    logic [GID_W-1:0]     ptr, win_id;
    logic [GID_W:0]       win_sum;
    logic [2*NUM_REQ-1:0] req_rot;
    logic                 win_vld;
    logic [SIZE_W-1:0]    raw_size;
    logic [CNT_W-1:0]     wait_cnt;
    logic                 timeout_hit;

    // Rotate requests so the pointer lands on bit 0; the lowest set bit is the winner.
    always_comb begin
        req_rot = {req_val, req_val} >> ptr;
        win_vld = 1'b0;
        win_sum = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                win_vld = 1'b1;
                win_sum = {1'b0, ptr} + (GID_W+1)'(k);
            end
        end
        if (win_sum >= (GID_W+1)'(NUM_REQ)) begin
            win_sum = win_sum - (GID_W+1)'(NUM_REQ);
        end
        win_id = win_sum[GID_W-1:0];
    end

    always_comb begin
        win_hdr  = '0;
        raw_size = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_id == GID_W'(i)) begin
                win_hdr.msg = req_msg[i*N_BITS +: N_BITS];
                win_hdr.cs  = req_cs[i*CS_BITS +: CS_BITS];
                raw_size    = req_size[i*SIZE_W +: SIZE_W];
            end
        end
        win_hdr.size = (raw_size > SIZE_W'(N_BITS)) ? SIZE_W'(N_BITS) : raw_size;
    end

    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_nxt           = state;
        req_rdy             = '0;
        resp_val            = '0;
        spi_packet_size_val = 1'b0;
        spi_cs_addr_val     = 1'b0;
        spi_recv_val        = 1'b0;
        spi_send_rdy        = 1'b0;
        case (state)
            IDLE: begin
                spi_send_rdy = 1'b1;
                if (win_vld) begin
                    req_rdy[win_id] = 1'b1;
                    state_nxt       = (win_hdr.size == '0) ? RESP : CONFIG;
                end
            end
            CONFIG: begin
                spi_packet_size_val = 1'b1;
                spi_cs_addr_val     = 1'b1;
                state_nxt           = ISSUE;
            end
            ISSUE: begin
                spi_recv_val = 1'b1;
                if (spi_recv_rdy) state_nxt = WAIT_RESP;
            end
            WAIT_RESP: begin
                spi_send_rdy = 1'b1;
                if (spi_send_val || timeout_hit) state_nxt = RESP;
            end
            RESP: begin
                resp_val[grant_id] = 1'b1;
                if (resp_rdy[grant_id]) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (reset) begin
            req_rdy             = '0;
            resp_val            = '0;
            spi_packet_size_val = 1'b0;
            spi_cs_addr_val     = 1'b0;
            spi_recv_val        = 1'b0;
            spi_send_rdy        = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            grant_id <= '0;
            wait_cnt <= '0;
            resp_msg <= '0;
            resp_err <= 1'b0;
            hdr      <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        hdr      <= win_hdr;
                        grant_id <= win_id;
                        resp_msg <= '0;
                        resp_err <= 1'b0;
                    end
                end
                ISSUE: wait_cnt <= '0;
                WAIT_RESP: begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                    // A response landing on the expiry cycle still counts as success.
                    if (spi_send_val) begin
                        resp_msg <= spi_send_msg;
                        resp_err <= 1'b0;
                    end else if (timeout_hit) begin
                        resp_msg <= '0;
                        resp_err <= 1'b1;
                    end
                end
                RESP: begin
                    if (resp_rdy[grant_id]) begin
                        ptr <= (grant_id == GID_W'(NUM_REQ - 1)) ? '0 : grant_id + GID_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign spi_packet_size = hdr.size;
    assign spi_cs_addr     = hdr.cs;
    assign spi_recv_msg    = hdr.msg;
    assign busy            = (state != IDLE);
endmodule

// File: tb/tb_spi_master_arbiter.sv
module tb_spi_master_arbiter;
    localparam int NR = 3;
    localparam int NB = 32;
    localparam int TO = 16;

    logic        clk, reset;
    logic [2:0]  req_val, req_rdy, resp_val, resp_rdy;
    logic [95:0] req_msg;
    logic [17:0] req_size;
    logic [5:0]  req_cs;
    logic [31:0] resp_msg, spi_recv_msg, spi_send_msg;
    logic        resp_err, spi_packet_size_val, spi_cs_addr_val;
    logic [5:0]  spi_packet_size;
    logic [1:0]  spi_cs_addr, grant_id;
    logic        spi_recv_val, spi_recv_rdy, spi_send_val, spi_send_rdy, busy;

    int n_checks, n_errors, model_ptr;

    spi_master_arbiter #(.NUM_REQ(NR), .N_BITS(NB), .CS_BITS(2), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_val(req_val), .req_rdy(req_rdy), .req_msg(req_msg), .req_size(req_size), .req_cs(req_cs),
        .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_msg(resp_msg), .resp_err(resp_err),
        .spi_packet_size_val(spi_packet_size_val), .spi_packet_size(spi_packet_size),
        .spi_cs_addr_val(spi_cs_addr_val), .spi_cs_addr(spi_cs_addr),
        .spi_recv_val(spi_recv_val), .spi_recv_rdy(spi_recv_rdy), .spi_recv_msg(spi_recv_msg),
        .spi_send_val(spi_send_val), .spi_send_rdy(spi_send_rdy), .spi_send_msg(spi_send_msg),
        .busy(busy), .grant_id(grant_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Reference round-robin: first valid requester at or after the pointer, wrapping.
    function automatic int rr_pick(input logic [2:0] m, input int p);
        for (int k = 0; k < NR; k++) begin
            if (m[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [31:0] m, input int sz, input logic [1:0] cs);
        req_msg[i*32 +: 32] = m;
        req_size[i*6 +: 6]  = 6'(sz);
        req_cs[i*2 +: 2]    = cs;
    endtask

    task automatic drain(output bit ok);
        ok = 1'b0;
        spi_recv_rdy = 1'b1; spi_send_val = 1'b1; spi_send_msg = '0; resp_rdy = 3'b111;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk); #1;
            if (!busy) begin ok = 1'b1; break; end
        end
        spi_recv_rdy = 1'b0; spi_send_val = 1'b0; resp_rdy = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_val = 3'b111; spi_send_val = 1'b1;
        for (int i = 0; i < NR; i++) set_req(i, 32'hFFFF_FFFF, 8, 2'd3);
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (req_rdy !== 3'b000) begin n_errors++; $display("FAIL rst_req_rdy got=%b exp=000", req_rdy); end
        n_checks++; if (resp_val !== 3'b000) begin n_errors++; $display("FAIL rst_resp_val got=%b exp=000", resp_val); end
        n_checks++; if (spi_send_rdy !== 1'b0) begin n_errors++; $display("FAIL rst_send_rdy got=%b exp=0", spi_send_rdy); end
        n_checks++; if ({spi_recv_val, spi_packet_size_val, spi_cs_addr_val} !== 3'b000) begin n_errors++; $display("FAIL rst_spi_vals got=%b exp=000", {spi_recv_val, spi_packet_size_val, spi_cs_addr_val}); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
        n_checks++; if (grant_id !== 2'd0) begin n_errors++; $display("FAIL rst_grant_id got=%0d exp=0", grant_id); end
        n_checks++; if ({resp_err, resp_msg} !== 33'd0) begin n_errors++; $display("FAIL rst_resp got=%h/%b exp=0/0", resp_msg, resp_err); end
        n_checks++; if ({spi_packet_size, spi_cs_addr, spi_recv_msg} !== 40'd0) begin n_errors++; $display("FAIL rst_latched got=%h exp=0", {spi_packet_size, spi_cs_addr, spi_recv_msg}); end
        req_val = '0; spi_send_val = 1'b0;
        @(negedge clk); reset = 1'b0;
        @(negedge clk); #1;
        n_checks++; if (spi_send_rdy !== 1'b1) begin n_errors++; $display("FAIL idle_send_rdy got=%b exp=1", spi_send_rdy); end
        model_ptr = 0;
    endtask

    task automatic test_back_to_back();
        int got;
        set_req(0, 32'h1111_1111, 8, 2'd0);
        set_req(1, 32'h2222_2222, 8, 2'd3);
        got = 0;
        @(negedge clk);
        req_val = 3'b011; spi_recv_rdy = 1'b1; spi_send_val = 1'b1; spi_send_msg = 32'hCAFE_0000; resp_rdy = 3'b011;
        for (int c = 0; c < 60 && got < 4; c++) begin
            #1;
            if (resp_val != 3'b000) begin
                n_checks++; if (grant_id !== 2'(got % 2)) begin n_errors++; $display("FAIL b2b_grant[%0d] got=%0d exp=%0d", got, grant_id, got % 2); end
                n_checks++; if (resp_val !== (3'b001 << (got % 2))) begin n_errors++; $display("FAIL b2b_resp_val[%0d] got=%b", got, resp_val); end
                n_checks++; if (resp_msg !== 32'hCAFE_0000) begin n_errors++; $display("FAIL b2b_msg[%0d] got=%h exp=cafe0000", got, resp_msg); end
                got++;
                if (got == 4) begin req_val = '0; spi_recv_rdy = 1'b0; spi_send_val = 1'b0; end
            end
            @(negedge clk);
        end
        resp_rdy = '0;
        n_checks++; if (got != 4) begin n_errors++; $display("FAIL b2b_count got=%0d exp=4", got); end
        model_ptr = 2;
    endtask

    task automatic test_basic();
        @(negedge clk);
        set_req(0, 32'hA5A5_A5A5, 32, 2'd1); req_val = 3'b001; #1;
        n_checks++; if (req_rdy !== 3'b001) begin n_errors++; $display("FAIL basic_req_rdy got=%b exp=001", req_rdy); end
        @(negedge clk); req_val = '0; #1;
        n_checks++; if ({spi_packet_size_val, spi_cs_addr_val} !== 2'b11) begin n_errors++; $display("FAIL basic_cfg_pulse got=%b exp=11", {spi_packet_size_val, spi_cs_addr_val}); end
        n_checks++; if (spi_packet_size !== 6'd32 || spi_cs_addr !== 2'd1) begin n_errors++; $display("FAIL basic_cfg got=%0d/%0d exp=32/1", spi_packet_size, spi_cs_addr); end
        n_checks++; if (busy !== 1'b1 || spi_send_rdy !== 1'b0) begin n_errors++; $display("FAIL basic_cfg_busy got=%b%b exp=10", busy, spi_send_rdy); end
        @(negedge clk); #1;
        n_checks++; if (spi_packet_size_val !== 1'b0) begin n_errors++; $display("FAIL basic_cfg_one_cycle got=%b exp=0", spi_packet_size_val); end
        n_checks++; if (spi_recv_val !== 1'b1 || spi_recv_msg !== 32'hA5A5_A5A5) begin n_errors++; $display("FAIL basic_issue got=%b/%h exp=1/a5a5a5a5", spi_recv_val, spi_recv_msg); end
        @(negedge clk); #1;
        n_checks++; if (spi_recv_val !== 1'b1) begin n_errors++; $display("FAIL basic_issue_hold got=%b exp=1", spi_recv_val); end
        spi_recv_rdy = 1'b1;
        @(negedge clk); spi_recv_rdy = 1'b0; #1;
        n_checks++; if (spi_send_rdy !== 1'b1 || spi_recv_val !== 1'b0) begin n_errors++; $display("FAIL basic_wait got=%b%b exp=10", spi_send_rdy, spi_recv_val); end
        spi_send_val = 1'b1; spi_send_msg = 32'h1234_5678;
        @(negedge clk); spi_send_val = 1'b0; #1;
        n_checks++; if (resp_val !== 3'b001) begin n_errors++; $display("FAIL basic_resp_val got=%b exp=001", resp_val); end
        n_checks++; if (resp_msg !== 32'h1234_5678 || resp_err !== 1'b0) begin n_errors++; $display("FAIL basic_resp got=%h/%b exp=12345678/0", resp_msg, resp_err); end
        @(negedge clk); #1;
        n_checks++; if (resp_val !== 3'b001 || resp_msg !== 32'h1234_5678) begin n_errors++; $display("FAIL basic_resp_hold got=%b/%h", resp_val, resp_msg); end
        resp_rdy = 3'b001;
        @(negedge clk); resp_rdy = '0; #1;
        n_checks++; if (busy !== 1'b0 || resp_val !== 3'b000) begin n_errors++; $display("FAIL basic_done got=%b/%b exp=0/000", busy, resp_val); end
        model_ptr = 1;
    endtask

    task automatic test_size_zero();
        int seen;
        bit spi_seen;
        seen = -1; spi_seen = 1'b0;
        @(negedge clk);
        set_req(1, 32'hFFFF_0000, 0, 2'd1); req_val = 3'b010; #1;
        n_checks++; if (req_rdy !== 3'b010) begin n_errors++; $display("FAIL zero_req_rdy got=%b exp=010", req_rdy); end
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 1) req_val = '0;
            #1;
            if (spi_recv_val || spi_packet_size_val || spi_cs_addr_val) spi_seen = 1'b1;
            if (resp_val != 3'b000 && seen < 0) seen = c;
        end
        n_checks++; if (seen < 1 || seen > 2) begin n_errors++; $display("FAIL zero_latency got=%0d exp=1..2", seen); end
        n_checks++; if (spi_seen !== 1'b0) begin n_errors++; $display("FAIL zero_spi_activity got=%b exp=0", spi_seen); end
        n_checks++; if (resp_val !== 3'b010 || grant_id !== 2'd1) begin n_errors++; $display("FAIL zero_resp_val got=%b/%0d exp=010/1", resp_val, grant_id); end
        n_checks++; if (resp_msg !== 32'd0 || resp_err !== 1'b0) begin n_errors++; $display("FAIL zero_resp got=%h/%b exp=0/0", resp_msg, resp_err); end
        resp_rdy = 3'b010;
        @(negedge clk); resp_rdy = '0; #1;
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL zero_done got=%b exp=0", busy); end
        model_ptr = 2;
    endtask

    task automatic test_clamp();
        bit ok;
        @(negedge clk);
        set_req(0, 32'h0F0F_0F0F, 40, 2'd2); req_val = 3'b001;
        @(negedge clk); req_val = '0; #1;
        n_checks++; if (spi_packet_size_val !== 1'b1 || spi_packet_size !== 6'd32) begin n_errors++; $display("FAIL clamp_size got=%b/%0d exp=1/32", spi_packet_size_val, spi_packet_size); end
        n_checks++; if (spi_cs_addr !== 2'd2) begin n_errors++; $display("FAIL clamp_cs got=%0d exp=2", spi_cs_addr); end
        drain(ok);
        n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL clamp_drain got=%b exp=1", ok); end
        model_ptr = 1;
    endtask

    task automatic test_timeout();
        int n_wait;
        bit late;
        n_wait = 0; late = 1'b0;
        @(negedge clk);
        set_req(2, 32'h5555_AAAA, 16, 2'd3); req_val = 3'b100; #1;
        n_checks++; if (req_rdy !== 3'b100) begin n_errors++; $display("FAIL to_req_rdy got=%b exp=100", req_rdy); end
        @(negedge clk); req_val = '0;
        @(negedge clk); spi_recv_rdy = 1'b1;
        @(negedge clk); spi_recv_rdy = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (resp_val != 3'b000) break;
            if (busy && spi_send_rdy) n_wait++;
            @(negedge clk);
        end
        n_checks++; if (n_wait != TO) begin n_errors++; $display("FAIL to_wait_cycles got=%0d exp=%0d", n_wait, TO); end
        n_checks++; if (resp_val !== 3'b100) begin n_errors++; $display("FAIL to_resp_val got=%b exp=100", resp_val); end
        n_checks++; if (resp_err !== 1'b1 || resp_msg !== 32'd0) begin n_errors++; $display("FAIL to_resp got=%h/%b exp=0/1", resp_msg, resp_err); end
        resp_rdy = 3'b100;
        @(negedge clk);
        resp_rdy = '0; spi_send_val = 1'b1; spi_send_msg = 32'hDEAD_BEEF; #1;
        n_checks++; if (spi_send_rdy !== 1'b1) begin n_errors++; $display("FAIL to_idle_send_rdy got=%b exp=1", spi_send_rdy); end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 1) spi_send_val = 1'b0;
            #1;
            if (resp_val != 3'b000 || busy) late = 1'b1;
        end
        spi_send_val = 1'b0;
        n_checks++; if (late !== 1'b0) begin n_errors++; $display("FAIL to_stale_discard got=%b exp=0", late); end
        model_ptr = 0;
    endtask

    task automatic test_reset_mid();
        bit stray, ok;
        stray = 1'b0;
        @(negedge clk);
        set_req(1, 32'h7777_7777, 8, 2'd1); req_val = 3'b010;
        @(negedge clk); req_val = '0;
        @(negedge clk); spi_recv_rdy = 1'b1;
        @(negedge clk); spi_recv_rdy = 1'b0; #1;
        n_checks++; if (spi_send_rdy !== 1'b1 || busy !== 1'b1) begin n_errors++; $display("FAIL mid_in_wait got=%b%b exp=11", spi_send_rdy, busy); end
        @(negedge clk);
        reset = 1'b1; req_val = 3'b011; resp_rdy = 3'b111; spi_send_val = 1'b1; #1;
        n_checks++; if ({req_rdy, resp_val} !== 6'd0) begin n_errors++; $display("FAIL mid_rst_hs got=%b/%b exp=0/0", req_rdy, resp_val); end
        n_checks++; if ({spi_send_rdy, spi_recv_val, spi_packet_size_val, spi_cs_addr_val} !== 4'd0) begin n_errors++; $display("FAIL mid_rst_spi got=%b exp=0000", {spi_send_rdy, spi_recv_val, spi_packet_size_val, spi_cs_addr_val}); end
        n_checks++; if (busy !== 1'b0 || grant_id !== 2'd0) begin n_errors++; $display("FAIL mid_rst_state got=%b/%0d exp=0/0", busy, grant_id); end
        @(negedge clk);
        reset = 1'b0; req_val = '0; spi_send_val = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            if (resp_val != 3'b000) stray = 1'b1;
        end
        resp_rdy = '0;
        n_checks++; if (stray !== 1'b0) begin n_errors++; $display("FAIL mid_no_resp got=%b exp=0", stray); end
        @(negedge clk);
        req_val = 3'b010; #1;
        n_checks++; if (req_rdy !== 3'b010) begin n_errors++; $display("FAIL mid_regrant got=%b exp=010", req_rdy); end
        @(negedge clk); req_val = '0; #1;
        n_checks++; if (grant_id !== 2'd1 || spi_packet_size_val !== 1'b1) begin n_errors++; $display("FAIL mid_cfg got=%0d/%b exp=1/1", grant_id, spi_packet_size_val); end
        drain(ok);
        n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL mid_drain got=%b exp=1", ok); end
        model_ptr = 2;
    endtask

    task automatic test_random();
        logic [31:0] m_msg[NR];
        int          m_size[NR];
        logic [1:0]  m_cs[NR];
        logic [2:0]  mask, exp_oh;
        logic [31:0] rsp, exp_msg;
        logic        exp_err;
        int          w, d, ex_size, st, n_wait, exp_wait, hold;
        for (int t = 0; t < 30; t++) begin
            mask = 3'($urandom_range(1, 7));
            for (int i = 0; i < NR; i++) begin
                m_msg[i]  = $urandom;
                m_size[i] = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 40);
                m_cs[i]   = 2'($urandom_range(0, 3));
                set_req(i, m_msg[i], m_size[i], m_cs[i]);
            end
            w       = rr_pick(mask, model_ptr);
            exp_oh  = 3'b001 << w;
            ex_size = (m_size[w] > NB) ? NB : m_size[w];
            d       = (t % 5 == 0) ? TO - 1 : $urandom_range(0, TO + 3);
            rsp     = $urandom;
            exp_msg = '0;
            exp_err = 1'b0;
            @(negedge clk); req_val = mask; #1;
            n_checks++; if (req_rdy !== exp_oh) begin n_errors++; $display("FAIL rnd%0d_grant got=%b exp=%b mask=%b", t, req_rdy, exp_oh, mask); end
            @(negedge clk); #1;
            n_checks++; if (req_rdy !== 3'b000) begin n_errors++; $display("FAIL rnd%0d_no_regrant got=%b exp=000", t, req_rdy); end
            req_val = '0;
            if (ex_size == 0) begin
                n_checks++; if (resp_val !== exp_oh || spi_packet_size_val !== 1'b0) begin n_errors++; $display("FAIL rnd%0d_zero got=%b/%b exp=%b/0", t, resp_val, spi_packet_size_val, exp_oh); end
            end else begin
                n_checks++; if (spi_packet_size_val !== 1'b1 || spi_packet_size !== 6'(ex_size)) begin n_errors++; $display("FAIL rnd%0d_size got=%b/%0d exp=1/%0d", t, spi_packet_size_val, spi_packet_size, ex_size); end
                n_checks++; if (spi_cs_addr !== m_cs[w]) begin n_errors++; $display("FAIL rnd%0d_cs got=%0d exp=%0d", t, spi_cs_addr, m_cs[w]); end
                @(negedge clk);
                st = $urandom_range(0, 2);
                for (int s = 0; s < st; s++) begin
                    #1;
                    n_checks++; if (spi_recv_val !== 1'b1) begin n_errors++; $display("FAIL rnd%0d_issue_hold got=%b exp=1", t, spi_recv_val); end
                    @(negedge clk);
                end
                spi_recv_rdy = 1'b1; #1;
                n_checks++; if (spi_recv_msg !== m_msg[w]) begin n_errors++; $display("FAIL rnd%0d_recv_msg got=%h exp=%h", t, spi_recv_msg, m_msg[w]); end
                @(negedge clk); spi_recv_rdy = 1'b0;
                n_wait = 0;
                for (int k = 0; k < 40; k++) begin
                    spi_send_val = (k == d); spi_send_msg = rsp; #1;
                    if (resp_val != 3'b000) break;
                    n_wait++;
                    @(negedge clk);
                end
                spi_send_val = 1'b0;
                exp_wait = (d < TO) ? d + 1 : TO;
                if (d < TO) exp_msg = rsp; else exp_err = 1'b1;
                n_checks++; if (n_wait != exp_wait) begin n_errors++; $display("FAIL rnd%0d_wait got=%0d exp=%0d", t, n_wait, exp_wait); end
                n_checks++; if (resp_val !== exp_oh || grant_id !== 2'(w)) begin n_errors++; $display("FAIL rnd%0d_resp_val got=%b/%0d exp=%b/%0d", t, resp_val, grant_id, exp_oh, w); end
            end
            n_checks++; if (resp_msg !== exp_msg || resp_err !== exp_err) begin n_errors++; $display("FAIL rnd%0d_resp got=%h/%b exp=%h/%b", t, resp_msg, resp_err, exp_msg, exp_err); end
            hold = $urandom_range(0, 2);
            for (int h = 0; h < hold; h++) begin
                resp_rdy = ~exp_oh & 3'($urandom_range(0, 7));
                @(negedge clk); #1;
                n_checks++; if (resp_val !== exp_oh || resp_msg !== exp_msg) begin n_errors++; $display("FAIL rnd%0d_hold got=%b/%h exp=%b/%h", t, resp_val, resp_msg, exp_oh, exp_msg); end
            end
            resp_rdy = exp_oh | 3'($urandom_range(0, 7));
            @(negedge clk); resp_rdy = '0; #1;
            n_checks++; if (busy !== 1'b0 || resp_val !== 3'b000) begin n_errors++; $display("FAIL rnd%0d_done got=%b/%b exp=0/000", t, busy, resp_val); end
            model_ptr = (w + 1) % NR;
        end
    endtask

    initial begin
        n_checks = 0; n_errors = 0; model_ptr = 0;
        reset = 1'b1; req_val = '0; resp_rdy = '0;
        req_msg = '0; req_size = '0; req_cs = '0;
        spi_recv_rdy = 1'b0; spi_send_val = 1'b0; spi_send_msg = '0;
        test_reset();
        test_back_to_back();
        test_basic();
        test_size_zero();
        test_clamp();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
